// File: rtl/pipe_ctrl_pkg.sv
// Shared types and widths for the pipeline sequencer.
//   state_e  : sequencer state encoding
//   RegIdxW  : register-index width (8 architectural registers)
//   CntW     : width of the flush/drain down-counter
package pipe_ctrl_pkg;

  localparam int unsigned RegIdxW = 3;
  localparam int unsigned CntW    = 3;

  typedef enum logic [2:0] {
    StFill,
    StRun,
    StMemWait,
    StFlush,
    StDrain,
    StHalted
  } state_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator: flags when the instruction in decode reads a register that
// the load currently in execute has not yet written.
//   ex_load               : execute holds a memory read
//   ex_rd                 : destination of the execute instruction
//   id_rs1, id_rs2        : decode source registers
//   id_rs1_used/rs2_used  : the corresponding source is actually read
//   hazard                : decode must wait one cycle
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic               ex_load,
  input  logic [RegIdxW-1:0] ex_rd,
  input  logic [RegIdxW-1:0] id_rs1,
  input  logic [RegIdxW-1:0] id_rs2,
  input  logic               id_rs1_used,
  input  logic               id_rs2_used,
  output logic               hazard
);

  assign hazard = ex_load && ((id_rs1_used && (id_rs1 == ex_rd)) ||
                              (id_rs2_used && (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: drives fetch/decode/execute enables and bubble controls, resolving
// memory back-pressure, taken branches, load-use hazards and halt requests by fixed priority.
//   clk, rst_n                     : clock, asynchronous active-low reset
//   mem_busy, br_taken             : back-pressure, taken-branch pulse
//   ex_load, ex_rd, id_rs*         : load-use hazard inputs
//   halt_req, resume               : halt level request, resume pulse
//   fetch_en, decode_en, exec_en   : stage register enables
//   fetch_bubble, decode_bubble    : invalidate decode input / zero execute controls
//   pc_redirect, halted            : branch target select, core stopped
// Optional: define PIPE_CTRL_PERF_EN to add saturating stall_cnt and flush_cnt outputs.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mem_busy,
  input  logic               br_taken,
  input  logic               ex_load,
  input  logic [RegIdxW-1:0] ex_rd,
  input  logic [RegIdxW-1:0] id_rs1,
  input  logic [RegIdxW-1:0] id_rs2,
  input  logic               id_rs1_used,
  input  logic               id_rs2_used,
  input  logic               halt_req,
  input  logic               resume,
  output logic               fetch_en,
  output logic               decode_en,
  output logic               exec_en,
  output logic               fetch_bubble,
  output logic               decode_bubble,
  output logic               pc_redirect,
  output logic               halted
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [15:0]        stall_cnt,
  output logic [15:0]        flush_cnt
`endif
);

  // The redirect/halt cycle itself is the first bubble, so the counter covers the remainder.
  localparam logic [CntW-1:0] FlushLoad = CntW'(FLUSH_CYCLES - 1);
  localparam logic [CntW-1:0] DrainLoad = CntW'(DRAIN_CYCLES - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            br_pend_q, br_pend_d;
  logic            hazard;
  logic            br_eff;

  hazard_detect u_hazard_detect (
    .ex_load     (ex_load),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .hazard      (hazard)
  );

  // A branch that arrived during a freeze is replayed on the first unfrozen cycle.
  assign br_eff = br_taken || br_pend_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFill;
      cnt_q     <= '0;
      br_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      br_pend_q <= br_pend_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    br_pend_d = br_pend_q;
    unique case (state_q)
      StFill: state_d = StRun;
      StRun, StMemWait: begin
        if (mem_busy) begin
          state_d = StMemWait;
          if (br_taken) br_pend_d = 1'b1;
        end else if (br_eff) begin
          br_pend_d = 1'b0;
          cnt_d     = FlushLoad;
          state_d   = (FlushLoad == '0) ? StRun : StFlush;
        end else if (hazard) begin
          state_d = StRun;
        end else if (halt_req) begin
          cnt_d   = DrainLoad;
          state_d = (DrainLoad == '0) ? StHalted : StDrain;
        end else begin
          state_d = StRun;
        end
      end
      StFlush: begin
        if (mem_busy) begin
          if (br_taken) br_pend_d = 1'b1;
        end else if (br_eff) begin
          br_pend_d = 1'b0;
          cnt_d     = FlushLoad;
        end else if (cnt_q <= CntW'(1)) begin
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDrain: begin
        if (!mem_busy) begin
          if (cnt_q <= CntW'(1)) begin
            cnt_d   = '0;
            state_d = StHalted;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
      end
      StHalted: if (resume) state_d = StFill;
      default: state_d = StFill;
    endcase
  end

  always_comb begin
    fetch_en      = 1'b0;
    decode_en     = 1'b0;
    exec_en       = 1'b0;
    fetch_bubble  = 1'b0;
    decode_bubble = 1'b0;
    pc_redirect   = 1'b0;
    halted        = 1'b0;
    if (!rst_n) begin
      // Outputs must reach reset values without waiting for a clock.
      fetch_bubble  = 1'b1;
      decode_bubble = 1'b1;
    end else begin
      unique case (state_q)
        StFill: begin
          {fetch_en, decode_en, exec_en}  = 3'b111;
          {fetch_bubble, decode_bubble}   = 2'b11;
        end
        StRun, StMemWait: begin
          if (mem_busy) begin
            // Full freeze: all defaults.
          end else if (br_eff) begin
            {fetch_en, decode_en, exec_en} = 3'b111;
            {fetch_bubble, decode_bubble}  = 2'b11;
            pc_redirect                    = 1'b1;
          end else if (hazard) begin
            exec_en       = 1'b1;
            decode_bubble = 1'b1;
          end else if (halt_req) begin
            decode_en    = 1'b1;
            exec_en      = 1'b1;
            fetch_bubble = 1'b1;
          end else begin
            {fetch_en, decode_en, exec_en} = 3'b111;
          end
        end
        StFlush: begin
          if (!mem_busy) begin
            {fetch_en, decode_en, exec_en} = 3'b111;
            {fetch_bubble, decode_bubble}  = 2'b11;
            pc_redirect                    = br_eff;
          end
        end
        StDrain: begin
          if (!mem_busy) begin
            decode_en    = 1'b1;
            exec_en      = 1'b1;
            fetch_bubble = 1'b1;
          end
        end
        StHalted: halted = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!fetch_en && (state_q != StHalted) && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (pc_redirect && (flush_cnt != 16'hFFFF)) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with default parameters (FLUSH_CYCLES=2, DRAIN_CYCLES=3).
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mem_busy = 1'b0, br_taken = 1'b0, ex_load = 1'b0;
  logic [2:0] ex_rd = '0, id_rs1 = '0, id_rs2 = '0;
  logic       id_rs1_used = 1'b0, id_rs2_used = 1'b0, halt_req = 1'b0, resume = 1'b0;
  logic       fetch_en, decode_en, exec_en, fetch_bubble, decode_bubble, pc_redirect, halted;

  int vectors = 0;
  int miscompares = 0;

  // {fetch_en, decode_en, exec_en, fetch_bubble, decode_bubble, pc_redirect, halted}
  localparam logic [6:0] RSTV    = 7'b0001100;
  localparam logic [6:0] FILLV   = 7'b1111100;
  localparam logic [6:0] RUNV    = 7'b1110000;
  localparam logic [6:0] LUV     = 7'b0010100;
  localparam logic [6:0] BRV     = 7'b1111110;
  localparam logic [6:0] FLV     = 7'b1111100;
  localparam logic [6:0] STALLV  = 7'b0000000;
  localparam logic [6:0] DRAINV  = 7'b0111000;
  localparam logic [6:0] HALTEDV = 7'b0000001;

  pipeline_ctrl #(.FLUSH_CYCLES(2), .DRAIN_CYCLES(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_busy      (mem_busy),
    .br_taken      (br_taken),
    .ex_load       (ex_load),
    .ex_rd         (ex_rd),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_rs1_used   (id_rs1_used),
    .id_rs2_used   (id_rs2_used),
    .halt_req      (halt_req),
    .resume        (resume),
    .fetch_en      (fetch_en),
    .decode_en     (decode_en),
    .exec_en       (exec_en),
    .fetch_bubble  (fetch_bubble),
    .decode_bubble (decode_bubble),
    .pc_redirect   (pc_redirect),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    #1;
    obs = {fetch_en, decode_en, exec_en, fetch_bubble, decode_bubble, pc_redirect, halted};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset and fill
    chk("reset", RSTV);
    tick(); chk("reset_held", RSTV);
    tick(); rst_n = 1'b1; chk("fill", FILLV);
    tick(); chk("run0", RUNV);
    tick(); chk("run1", RUNV);

    // Load-use on rs2, then back to normal
    ex_load = 1'b1; ex_rd = 3'd3; id_rs2 = 3'd3; id_rs2_used = 1'b1;
    chk("loaduse_rs2", LUV);
    tick(); ex_load = 1'b0; chk("after_loaduse", RUNV);
    // Matching rs1 that is not read: no hazard
    ex_load = 1'b1; ex_rd = 3'd5; id_rs1 = 3'd5; id_rs1_used = 1'b0; id_rs2 = 3'd1;
    chk("rs1_unused", RUNV);
    tick(); id_rs1_used = 1'b1; chk("loaduse_rs1", LUV);
    tick(); ex_load = 1'b0; chk("no_load", RUNV);
    id_rs1_used = 1'b0; id_rs2_used = 1'b0;

    // Taken branch: 2 bubble cycles total
    tick(); br_taken = 1'b1; chk("branch", BRV);
    tick(); br_taken = 1'b0; chk("flush1", FLV);
    tick(); chk("flush_done", RUNV);

    // Branch and load-use together: branch wins
    tick(); br_taken = 1'b1; ex_load = 1'b1; ex_rd = 3'd2; id_rs1 = 3'd2; id_rs1_used = 1'b1;
    chk("br_over_loaduse", BRV);
    tick(); br_taken = 1'b0; ex_load = 1'b0; id_rs1_used = 1'b0; chk("br_lu_flush", FLV);
    tick(); chk("br_lu_run", RUNV);

    // Memory busy for 4 cycles, branch arrives in cycle 2
    tick(); mem_busy = 1'b1; chk("busy1", STALLV);
    tick(); br_taken = 1'b1; chk("busy2_br", STALLV);
    tick(); br_taken = 1'b0; chk("busy3", STALLV);
    tick(); chk("busy4", STALLV);
    tick(); mem_busy = 1'b0; chk("busy_exit_redirect", BRV);
    tick(); chk("busy_flush", FLV);
    tick(); chk("busy_run", RUNV);

    // Halt: 3 draining cycles then halted; halt_req ignored while halted
    tick(); halt_req = 1'b1; chk("drain1", DRAINV);
    tick(); chk("drain2", DRAINV);
    tick(); chk("drain3", DRAINV);
    tick(); chk("halted1", HALTEDV);
    tick(); br_taken = 1'b1; chk("halted_ignore_br", HALTEDV);
    tick(); br_taken = 1'b0; halt_req = 1'b0; resume = 1'b1; chk("resume_cycle", HALTEDV);
    tick(); resume = 1'b0; chk("resume_fill", FILLV);
    tick(); chk("resume_run", RUNV);

    // Drain freezes under mem_busy with the counter held
    tick(); halt_req = 1'b1; chk("drainb1", DRAINV);
    tick(); mem_busy = 1'b1; chk("drainb_busy", STALLV);
    tick(); mem_busy = 1'b0; chk("drainb2", DRAINV);
    tick(); chk("drainb3", DRAINV);
    tick(); halt_req = 1'b0; chk("drainb_halted", HALTEDV);
    tick(); resume = 1'b1; chk("drainb_resume", HALTEDV);
    tick(); resume = 1'b0; chk("drainb_fill", FILLV);
    tick(); chk("drainb_run", RUNV);

    // Reset mid-flush is asynchronous
    tick(); br_taken = 1'b1; chk("rf_branch", BRV);
    tick(); br_taken = 1'b0; chk("rf_flush", FLV);
    #2; rst_n = 1'b0; chk("rf_async_reset", RSTV);
    tick(); chk("rf_reset_held", RSTV);
    rst_n = 1'b1; chk("rf_fill", FILLV);
    tick(); chk("rf_run", RUNV);

    // A pending branch does not survive reset
    tick(); mem_busy = 1'b1; br_taken = 1'b1; chk("pend_busy", STALLV);
    tick(); br_taken = 1'b0; rst_n = 1'b0; chk("pend_reset", RSTV);
    tick(); mem_busy = 1'b0; rst_n = 1'b1; chk("pend_fill", FILLV);
    tick(); chk("pend_run_no_redirect", RUNV);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
